// File: rtl/lock_scheduler.sv
// -----------------------------------------------------------------------------
// lock_scheduler
//   Sequences one gondola through a canal lock per request. A request from
//   either side is latched as pending. IDLE grants one side round-robin. The
//   pound is pumped to the arrival side's level and that side's door is opened
//   for DOOR_TIME cycles. The pound is then pumped to the opposite side's level
//   and the opposite door is opened. If an adjust phase needs more than
//   MAX_PULSES pump pulses, a sticky fault is raised and nothing further is
//   granted until reset.
//
// Request/grant handshake: a request input acts as "valid" for one gondola.
// It is captured on every posedge where it is high, and it needs no hold.
// grant_<side> acts as the acknowledge: it is a one-cycle pulse, issued in the
// cycle after IDLE accepts that side. Repeated requests collapse into one
// pending service. No back-pressure is exposed; requests are never lost
// unless reset intervenes.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   outer_req, inner_req    arrival requests (sampled, set pending)
//   water_level[16:0]       measured pound level, unsigned
//   inc/dec_water_level     one-cycle pump pulses
//   outer/inner_door_open   door-open commands
//   grant_outer/inner       one-cycle acceptance pulses
//   busy                    high whenever the FSM is not in IDLE
//   fault                   sticky pump-timeout flag
//   o_dbg_state[2:0]        current FSM state, for observation
// -----------------------------------------------------------------------------
module lock_scheduler #(
  parameter int unsigned INNER      = 2800,
  parameter int unsigned OUTER      = 0,
  parameter int unsigned TOLERANCE  = 168,
  parameter int unsigned DOOR_TIME  = 5,
  parameter int unsigned SETTLE     = 2,
  parameter int unsigned MAX_PULSES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        outer_req,
  input  logic        inner_req,
  input  logic [16:0] water_level,
  output logic        inc_water_level,
  output logic        dec_water_level,
  output logic        outer_door_open,
  output logic        inner_door_open,
  output logic        grant_outer,
  output logic        grant_inner,
  output logic        busy,
  output logic        fault,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ADJ_ARR    = 3'd1,
    S_SETTLE_ARR = 3'd2,
    S_OPEN_ARR   = 3'd3,
    S_ADJ_DEP    = 3'd4,
    S_SETTLE_DEP = 3'd5,
    S_OPEN_DEP   = 3'd6
  } state_t;

  // Door-open thresholds, clamped so that extreme parameters can neither
  // underflow nor exceed the 17-bit level range.
  localparam int unsigned OUTER_LIM_I = (OUTER + TOLERANCE > 131071) ? 131071 : OUTER + TOLERANCE;
  localparam int unsigned INNER_MIN_I = (INNER > TOLERANCE) ?
                                        ((INNER - TOLERANCE > 131071) ? 131071 : INNER - TOLERANCE) : 0;
  localparam logic [16:0] OUTER_LIM = OUTER_LIM_I[16:0];
  localparam logic [16:0] INNER_MIN = INNER_MIN_I[16:0];

  // A single counter serves both settle and door timing, so it is sized for the larger.
  localparam int unsigned CNT_MAX = (DOOR_TIME > SETTLE) ? DOOR_TIME : SETTLE;
  localparam int CW = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam int PW = (MAX_PULSES < 2) ? 1 : $clog2(MAX_PULSES + 1);

  state_t          r_state;
  logic            r_pend_outer;
  logic            r_pend_inner;
  logic            r_last_inner;   // side served most recently (1 = inner)
  logic            r_dir;          // arrival side of current service (1 = inner)
  logic            r_fault;
  logic            r_grant_outer;
  logic            r_grant_inner;
  logic            r_inc;
  logic            r_dec;
  logic            r_outer_door;
  logic            r_inner_door;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_pulses;

  logic w_outer_ok;
  logic w_inner_ok;
  logic w_pend_outer;
  logic w_pend_inner;
  logic w_pick_inner;
  logic w_tgt_inner;
  logic w_tgt_ok;

  assign w_outer_ok   = (water_level <= OUTER_LIM);
  assign w_inner_ok   = (water_level >= INNER_MIN);
  // A request sampled this cycle counts as pending for arbitration now.
  assign w_pend_outer = r_pend_outer | outer_req;
  assign w_pend_inner = r_pend_inner | inner_req;
  // On a tie, serve the side that was not served last.
  assign w_pick_inner = w_pend_inner & (~w_pend_outer | ~r_last_inner);
  // The arrival leg targets the arrival side; the departure leg targets the opposite side.
  assign w_tgt_inner  = (r_state == S_ADJ_ARR) ? r_dir : ~r_dir;
  assign w_tgt_ok     = w_tgt_inner ? w_inner_ok : w_outer_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pend_outer  <= 1'b0;
      r_pend_inner  <= 1'b0;
      r_last_inner  <= 1'b1;
      r_dir         <= 1'b0;
      r_fault       <= 1'b0;
      r_grant_outer <= 1'b0;
      r_grant_inner <= 1'b0;
      r_inc         <= 1'b0;
      r_dec         <= 1'b0;
      r_outer_door  <= 1'b0;
      r_inner_door  <= 1'b0;
      r_cnt         <= '0;
      r_pulses      <= '0;
    end else begin
      r_grant_outer <= 1'b0;
      r_grant_inner <= 1'b0;
      r_inc         <= 1'b0;
      r_dec         <= 1'b0;
      r_pend_outer  <= w_pend_outer;
      r_pend_inner  <= w_pend_inner;

      case (r_state)
        S_IDLE: begin
          if (!r_fault && (w_pend_outer || w_pend_inner)) begin
            if (w_pick_inner) begin
              r_pend_inner  <= 1'b0;
              r_grant_inner <= 1'b1;
            end else begin
              r_pend_outer  <= 1'b0;
              r_grant_outer <= 1'b1;
            end
            r_dir    <= w_pick_inner;
            r_pulses <= '0;
            r_state  <= S_ADJ_ARR;
          end
        end

        S_ADJ_ARR, S_ADJ_DEP: begin
          if (w_tgt_ok) begin
            if (w_tgt_inner) r_inner_door <= 1'b1;
            else             r_outer_door <= 1'b1;
            r_cnt   <= CW'(DOOR_TIME);
            r_state <= (r_state == S_ADJ_ARR) ? S_OPEN_ARR : S_OPEN_DEP;
          end else if (r_pulses == PW'(MAX_PULSES)) begin
            // The pulse budget is exhausted: this pulse is withheld.
            r_fault <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            if (w_tgt_inner) r_inc <= 1'b1;
            else             r_dec <= 1'b1;
            r_pulses <= r_pulses + PW'(1);
            r_cnt    <= CW'(SETTLE);
            r_state  <= (r_state == S_ADJ_ARR) ? S_SETTLE_ARR : S_SETTLE_DEP;
          end
        end

        // The pulse cycle itself is the first settle cycle.
        S_SETTLE_ARR, S_SETTLE_DEP: begin
          if (r_cnt > CW'(1)) r_cnt <= r_cnt - CW'(1);
          else r_state <= (r_state == S_SETTLE_ARR) ? S_ADJ_ARR : S_ADJ_DEP;
        end

        S_OPEN_ARR: begin
          if (r_cnt > CW'(1)) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_outer_door <= 1'b0;
            r_inner_door <= 1'b0;
            r_pulses     <= '0;
            r_state      <= S_ADJ_DEP;
          end
        end

        S_OPEN_DEP: begin
          if (r_cnt > CW'(1)) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_outer_door <= 1'b0;
            r_inner_door <= 1'b0;
            r_last_inner <= r_dir;
            r_state      <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign inc_water_level = r_inc;
  assign dec_water_level = r_dec;
  assign outer_door_open = r_outer_door;
  assign inner_door_open = r_inner_door;
  assign grant_outer     = r_grant_outer;
  assign grant_inner     = r_grant_inner;
  assign busy            = (r_state != S_IDLE);
  assign fault           = r_fault;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_lock_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lock_scheduler
//   Drives directed and random gondola requests into lock_scheduler. A water
//   plant moves the pound level by +/-350 per pump pulse, clamped to 0..2800.
//   A reference model predicts each service as a list of events: grant, pump
//   pulse, door run, and fault. Each event carries its spacing from the
//   previous event, its length (for door runs), and the expected busy level.
//   A monitor turns DUT outputs into the same events and compares them
//   against the expected queue.
// -----------------------------------------------------------------------------
module tb_lock_scheduler;

  localparam int INNER = 2800, OUTER = 0, TOL = 168;
  localparam int DOOR_TIME = 5, SETTLE = 2, MAX_PULSES = 16, STEP = 350;
  localparam int W = 21;  // {busy, kind[3:0], gap[7:0], len[7:0]}
  localparam int K_GO = 1, K_GI = 2, K_INC = 3, K_DEC = 4, K_DO = 5, K_DI = 6, K_F = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        outer_req, inner_req;
  logic [16:0] water_level;
  logic        inc_water_level, dec_water_level;
  logic        outer_door_open, inner_door_open;
  logic        grant_outer, grant_inner;
  logic        busy, fault;
  logic [2:0]  dbg_state;

  lock_scheduler #(
    .INNER(INNER), .OUTER(OUTER), .TOLERANCE(TOL),
    .DOOR_TIME(DOOR_TIME), .SETTLE(SETTLE), .MAX_PULSES(MAX_PULSES)
  ) dut (
    .clk(clk), .reset(reset),
    .outer_req(outer_req), .inner_req(inner_req),
    .water_level(water_level),
    .inc_water_level(inc_water_level), .dec_water_level(dec_water_level),
    .outer_door_open(outer_door_open), .inner_door_open(inner_door_open),
    .grant_outer(grant_outer), .grant_inner(grant_inner),
    .busy(busy), .fault(fault), .o_dbg_state(dbg_state)
  );

  // ---------------- shared state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0, n_pass = 0, n_fail = 0;
  int excl_viol = 0;
  bit mon_en = 0;
  int load_val = 0, load_seq = 0, load_seen = 0;
  bit plant_hold = 0;
  int m_level = 0;
  bit m_last_inner = 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_exp(input int kind, input int gap, input int len, input bit b);
    logic [W-1:0] t;
    t = {b, kind[3:0], gap[7:0], len[7:0]};
    exp_q.push_back(t);
  endtask

  function automatic bit target_met(input bit to_inner, input int lvl);
    return to_inner ? (lvl >= INNER - TOL) : (lvl <= OUTER + TOL);
  endfunction

  // One adjust-then-open leg toward a side; gap carries spacing between events.
  task automatic model_leg(input bit to_inner, input int door_len, inout int gap, output bit faulted);
    int  n = 0;
    bit  done = 0;
    faulted = 0;
    while (!done) begin
      if (target_met(to_inner, m_level)) begin
        push_exp(to_inner ? K_DI : K_DO, gap, door_len, 1'b1);
        gap  = DOOR_TIME + 1;
        done = 1;
      end else if (n == MAX_PULSES) begin
        push_exp(K_F, gap, 0, 1'b0);
        faulted = 1;
        done    = 1;
      end else begin
        push_exp(to_inner ? K_INC : K_DEC, gap, 0, 1'b1);
        n++;
        if (!plant_hold) begin
          if (to_inner) m_level = (m_level + STEP > INNER) ? INNER : m_level + STEP;
          else          m_level = (m_level < STEP) ? 0 : m_level - STEP;
        end
        gap = SETTLE + 1;
      end
    end
  endtask

  task automatic model_service(input bit side_inner, inout int gap, output bit faulted);
    push_exp(side_inner ? K_GI : K_GO, gap, 0, 1'b1);
    gap = 1;
    model_leg(side_inner, DOOR_TIME, gap, faulted);
    if (!faulted) model_leg(!side_inner, DOOR_TIME, gap, faulted);
    if (!faulted) m_last_inner = side_inner;
  endtask

  // ---------------- water plant ----------------
  task automatic run_plant();
    int w;
    water_level = '0;
    forever begin
      @(negedge clk);
      if (load_seq != load_seen) begin
        water_level = 17'(load_val);
        load_seen   = load_seq;
      end else if (!plant_hold) begin
        w = int'(water_level);
        if (inc_water_level === 1'b1) w = (w + STEP > INNER) ? INNER : w + STEP;
        if (dec_water_level === 1'b1) w = (w < STEP) ? 0 : w - STEP;
        water_level = 17'(w);
      end
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic observe(input int kind, input int gap, input int len, input bit b);
    logic [W-1:0] e;
    int g;
    g = (gap > 255) ? 255 : gap;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d gap=%0d len=%0d busy=%0d, expected no event",
               kind, g, len, b);
    end else begin
      e = exp_q.pop_front();
      if (int'(e[19:16]) == kind && int'(e[7:0]) == len && e[20] == b &&
          (e[15:8] == 8'd0 || int'(e[15:8]) == g)) begin
        n_pass++;
      end else begin
        n_fail++;
        $display("FAIL event: got kind=%0d gap=%0d len=%0d busy=%0d, expected kind=%0d gap=%0d len=%0d busy=%0d",
                 kind, g, len, b, e[19:16], e[15:8], e[7:0], e[20]);
      end
    end
  endtask

  task automatic run_monitor();
    int cyc = 0, last = 0, st_o = 0, st_i = 0, g_o = 0, g_i = 0;
    bit pd_o = 0, pd_i = 0, pf = 0, b_o = 0, b_i = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if ((grant_outer & grant_inner) === 1'b1 || (inc_water_level & dec_water_level) === 1'b1 ||
            (outer_door_open & inner_door_open) === 1'b1)
          excl_viol++;
        if (grant_outer === 1'b1)     begin observe(K_GO,  cyc - last, 0, busy === 1'b1); last = cyc; end
        if (grant_inner === 1'b1)     begin observe(K_GI,  cyc - last, 0, busy === 1'b1); last = cyc; end
        if (inc_water_level === 1'b1) begin observe(K_INC, cyc - last, 0, busy === 1'b1); last = cyc; end
        if (dec_water_level === 1'b1) begin observe(K_DEC, cyc - last, 0, busy === 1'b1); last = cyc; end
        if (outer_door_open === 1'b1 && !pd_o) begin st_o = cyc; g_o = cyc - last; b_o = (busy === 1'b1); last = cyc; end
        if (outer_door_open !== 1'b1 && pd_o) observe(K_DO, g_o, cyc - st_o, b_o);
        if (inner_door_open === 1'b1 && !pd_i) begin st_i = cyc; g_i = cyc - last; b_i = (busy === 1'b1); last = cyc; end
        if (inner_door_open !== 1'b1 && pd_i) observe(K_DI, g_i, cyc - st_i, b_i);
        if (fault === 1'b1 && !pf) begin observe(K_F, cyc - last, 0, busy === 1'b1); last = cyc; end
        pd_o = (outer_door_open === 1'b1);
        pd_i = (inner_door_open === 1'b1);
        pf   = (fault === 1'b1);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_level(input int v);
    load_val = v;
    load_seq++;
    m_level = v;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_req(input bit o, input bit i);
    @(negedge clk);
    outer_req = o;
    inner_req = i;
    @(negedge clk);
    outer_req = 1'b0;
    inner_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: timeout with %0d events outstanding, busy=%b, expected 0 and 0",
               name, exp_q.size(), busy);
      exp_q.delete();
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gap;
    bit f;
    int k;
    int lvl_tab[6];
    lvl_tab[0] = 0;    lvl_tab[1] = 168;  lvl_tab[2] = 169;
    lvl_tab[3] = 2631; lvl_tab[4] = 2632; lvl_tab[5] = 2800;

    reset = 1'b1;
    outer_req = 1'b0;
    inner_req = 1'b0;
    fork
      run_monitor();
      run_plant();
    join_none

    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_last_inner = 1;
    @(negedge clk);
    check("reset_outputs", {inc_water_level, dec_water_level, outer_door_open, inner_door_open,
                            grant_outer, grant_inner, busy, fault}, 0);
    check("reset_state_idle", dbg_state, 0);  // IDLE is encoded as zero
    mon_en = 1;

    // Simultaneous requests after reset: outer first, inner right after.
    set_level(0);
    gap = 0;
    model_service(0, gap, f);
    model_service(1, gap, f);
    pulse_req(1, 1);
    wait_done("tie_after_reset", 500);

    // Outer arrival at level 0: grant one cycle after the request.
    set_level(0);
    gap = 0;
    model_service(0, gap, f);
    @(negedge clk);
    outer_req = 1'b1;
    @(negedge clk);
    outer_req = 1'b0;
    check("grant_latency", {grant_outer, grant_inner}, 2'b10);
    wait_done("outer_from_zero", 400);

    // Inner arrival already within tolerance: door opens with no pumping.
    set_level(2700);
    gap = 0;
    model_service(1, gap, f);
    pulse_req(0, 1);
    wait_done("inner_at_2700", 400);

    // Outer request held during a service gives exactly one extra service.
    set_level(0);
    gap = 0;
    model_service(0, gap, f);
    model_service(0, gap, f);
    @(negedge clk);
    outer_req = 1'b1;
    repeat (21) @(negedge clk);
    outer_req = 1'b0;
    wait_done("held_request", 600);

    // Random requests, levels mixing threshold edges and random values.
    for (int t = 0; t < 12; t++) begin
      int sel, pat, lvl;
      bit first;
      sel = $urandom_range(0, 7);
      lvl = (sel < 6) ? lvl_tab[sel] : $urandom_range(0, INNER);
      pat = $urandom_range(0, 2);
      set_level(lvl);
      gap = 0;
      if (pat == 2) begin
        first = !m_last_inner;
        model_service(first, gap, f);
        model_service(!first, gap, f);
      end else begin
        model_service(pat == 1, gap, f);
      end
      pulse_req(pat != 1, pat != 0);
      wait_done("random_txn", 500);
    end

    // Reset during OPEN_DEP with an inner request pending.
    set_level(0);
    gap = 0;
    push_exp(K_GO, 0, 0, 1'b1);
    gap = 1;
    model_leg(0, DOOR_TIME, gap, f);
    model_leg(1, 2, gap, f);
    pulse_req(1, 0);
    repeat (4) @(negedge clk);
    pulse_req(0, 1);
    k = 0;
    while (inner_door_open !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("dep_door_reached", inner_door_open, 1);
    @(negedge clk);
    reset = 1'b1;
    inner_req = 1'b1;   // ignored: sampled while reset is high
    m_last_inner = 1;
    @(negedge clk);
    reset = 1'b0;
    inner_req = 1'b0;
    check("outputs_after_mid_reset", {inc_water_level, dec_water_level, outer_door_open, inner_door_open,
                                      grant_outer, grant_inner, busy, fault}, 0);
    repeat (40) @(negedge clk);
    wait_done("quiet_after_reset", 20);

    // Level held at 0: 16 inc pulses, then fault; afterwards nothing is granted.
    plant_hold = 1;
    set_level(0);
    gap = 0;
    model_service(1, gap, f);
    pulse_req(0, 1);
    wait_done("pump_timeout", 400);
    check("fault_set", fault, 1);
    check("busy_after_fault", busy, 0);
    pulse_req(1, 1);
    repeat (40) @(negedge clk);
    check("fault_sticky", fault, 1);
    check("idle_while_faulted", busy, 0);
    wait_done("no_grant_in_fault", 10);

    check("exclusive_outputs", excl_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
